icache_fill_ctrl: RTL

Controller for the 2-set × 2-way instruction cache built from the line storage blocks. It accepts fetch lookups, evaluates per-way tag matches, picks a victim by per-set LRU on a miss, collects a 16-word line from memory into a fill buffer, commits it to the chosen line in one write cycle, then replays the lookup. It also sequences a full-cache invalidate (flush) by clearing every line's valid bit.

---
 rtl/icache_fill_ctrl_if.sv | 50 +++++
 rtl/icache_fill_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/icache_fill_ctrl_if.sv
// Fetch, tag-lookup, memory-read and line-fill signals of the I-cache
// controller. The slave modport is the controller; the master modport is
// the environment around it: fetch unit, tag/valid datapath and memory.
interface icache_fill_ctrl_if #(
  parameter int TAG_W = 25,
  parameter int IDX_W = 1,
  parameter int WAYS  = 2,
  parameter int WORDS = 16
);
  logic                  req_valid;
  logic [31:0]           req_addr;
  logic                  req_ready;
  logic                  resp_valid;
  logic                  resp_way;
  logic [3:0]            resp_word;
  logic [IDX_W-1:0]      lk_index;
  logic [TAG_W-1:0]      lk_tag;
  logic [WAYS-1:0]       tag_match;
  logic [WAYS-1:0]       way_valid;
  logic                  mem_req;
  logic [31:0]           mem_addr;
  logic                  mem_ack;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  logic [WAYS-1:0]       fill_we;
  logic [IDX_W-1:0]      fill_index;
  logic [TAG_W-1:0]      fill_tag;
  logic                  fill_valid;
  logic [WORDS*32-1:0]   fill_data;
  logic                  flush;
  logic                  busy;
  logic [15:0]           hit_cnt;
  logic [15:0]           miss_cnt;

  modport slave (
    input  req_valid, req_addr, tag_match, way_valid,
           mem_ack, mem_rvalid, mem_rdata, flush,
    output req_ready, resp_valid, resp_way, resp_word, lk_index, lk_tag,
           mem_req, mem_addr, fill_we, fill_index, fill_tag, fill_valid,
           fill_data, busy, hit_cnt, miss_cnt
  );

  modport master (
    output req_valid, req_addr, tag_match, way_valid,
           mem_ack, mem_rvalid, mem_rdata, flush,
    input  req_ready, resp_valid, resp_way, resp_word, lk_index, lk_tag,
           mem_req, mem_addr, fill_we, fill_index, fill_tag, fill_valid,
           fill_data, busy, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Miss/fill/flush sequencer for a 2-set x 2-way instruction cache.
// Lookups hit in two cycles; a miss picks a victim (first invalid way,
// else the set's LRU way), gathers a 16-word line, commits it in one
// write cycle and replays the lookup, which then hits.
module icache_fill_ctrl #(
  parameter int TAG_W = 25,
  parameter int IDX_W = 1,
  parameter int WAYS  = 2,
  parameter int WORDS = 16
) (
  input  logic               clk,
  input  logic               reset,
  icache_fill_ctrl_if.slave  bus
);
  localparam int BEAT_W = $clog2(WORDS);
  localparam int SETS   = 1 << IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, FILL, COMMIT, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [31:2]         addr_q, addr_d;
  logic                replay_q, replay_d;
  logic                victim_q, victim_d;
  logic [SETS-1:0]     lru_q, lru_d;        // LRU[set] = way to evict next
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [IDX_W-1:0]    fset_q, fset_d;      // flush set counter
  logic [WORDS*32-1:0] buf_q, buf_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_way_q, resp_way_d;
  logic [3:0]          resp_word_q, resp_word_d;
  logic [15:0]         hit_q, hit_d, miss_q, miss_d;

  logic [IDX_W-1:0]    set_idx;
  logic [TAG_W-1:0]    set_tag;
  logic                unused_addr_bits;

  assign set_idx          = addr_q[6 +: IDX_W];
  assign set_tag          = addr_q[31 -: TAG_W];
  assign unused_addr_bits = ^bus.req_addr[1:0];

  // State register and all datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so update order inside this block is irrelevant.
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      replay_q     <= 1'b0;
      victim_q     <= 1'b0;
      lru_q        <= '0;
      beat_q       <= '0;
      fset_q       <= '0;
      // NOTE: the fill buffer is plain flops visible on fill_data, so it is
      // reset with everything else; a reset mid-fill never exposes stale words.
      buf_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_way_q   <= 1'b0;
      resp_word_q  <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      replay_q     <= replay_d;
      victim_q     <= victim_d;
      lru_q        <= lru_d;
      beat_q       <= beat_d;
      fset_q       <= fset_d;
      buf_q        <= buf_d;
      resp_valid_q <= resp_valid_d;
      resp_way_q   <= resp_way_d;
      resp_word_q  <= resp_word_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  // Next-state and FSM-driven outputs.
  always_comb begin
    // NOTE: every signal written here is defaulted first; a path that left
    // one unassigned would infer a latch.
    state_d        = state_q;
    addr_d         = addr_q;
    replay_d       = replay_q;
    victim_d       = victim_q;
    lru_d          = lru_q;
    beat_d         = beat_q;
    fset_d         = fset_q;
    buf_d          = buf_q;
    resp_valid_d   = 1'b0;
    resp_way_d     = resp_way_q;
    resp_word_d    = resp_word_q;
    hit_d          = hit_q;
    miss_d         = miss_q;
    bus.req_ready  = 1'b0;
    bus.mem_req    = 1'b0;
    bus.fill_we    = '0;
    bus.fill_index = set_idx;
    bus.fill_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.req_ready = ~bus.flush;
        if (bus.flush) begin
          fset_d  = '0;
          state_d = FLUSH;
        end else if (bus.req_valid) begin
          addr_d   = bus.req_addr[31:2];
          replay_d = 1'b0;
          state_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        if (|bus.tag_match) begin
          resp_valid_d   = 1'b1;
          resp_way_d     = ~bus.tag_match[0];
          resp_word_d    = addr_q[5:2];
          lru_d[set_idx] = bus.tag_match[0];
          if (!replay_q) hit_d = hit_q + 16'd1;
          state_d = IDLE;
        end else begin
          miss_d = miss_q + 16'd1;
          if (!bus.way_valid[0])      victim_d = 1'b0;
          else if (!bus.way_valid[1]) victim_d = 1'b1;
          else                        victim_d = lru_q[set_idx];
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          beat_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (bus.mem_rvalid) begin
          buf_d[beat_q*32 +: 32] = bus.mem_rdata;
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_W'(WORDS-1)) state_d = COMMIT;
        end
      end
      COMMIT: begin
        bus.fill_we[victim_q] = 1'b1;
        bus.fill_valid        = 1'b1;
        lru_d[set_idx]        = ~victim_q;
        replay_d              = 1'b1;
        state_d               = LOOKUP;
      end
      FLUSH: begin
        bus.fill_we    = '1;
        bus.fill_index = fset_q;
        lru_d          = '0;
        if (fset_q == IDX_W'(SETS-1)) state_d = IDLE;
        else                          fset_d  = fset_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_way   = resp_way_q;
  assign bus.resp_word  = resp_word_q;
  assign bus.lk_index   = set_idx;
  assign bus.lk_tag     = set_tag;
  assign bus.mem_addr   = {addr_q[31:6], 6'b0};
  assign bus.fill_tag   = set_tag;
  assign bus.fill_data  = buf_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.hit_cnt    = hit_q;
  assign bus.miss_cnt   = miss_q;
endmodule
